// File: rtl/core_cache_ctrl.sv
// ---------------------------------------------------------------------------
// core_cache_ctrl
//   Direct-mapped, write-through, no-write-allocate L1 cache controller.
//   Accepts one request at a time from the CPU-side request buffer, answers
//   read hits from the local arrays, refills a whole line on a read miss and
//   forwards every store to memory (merging it into the line on a hit).
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   cache_req_i ..      CPU request bus: req/op/index/tag/offset/wr_en/wr_data
//   cache_rd_data_o     read data, qualified by cache_data_ack_o
//   cache_addr_ack_o    request accepted (only while idle)
//   cache_data_ack_o    read data valid / store complete
//   mem_rd_*            line refill: req/addr held until ack, then beats
//   mem_wr_*            word store: req/addr/data/strb held until ack
// ---------------------------------------------------------------------------
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a request; addr_ack follows cache_req_i
// LOOKUP   | tag compare; read hit acks, write hit merges, read miss refills
// MISS_REQ | refill address presented until memory accepts it
// REFILL   | collecting LINE_WORDS beats into the line
// WR_MEM   | store presented to memory until accepted
// ---------------------------------------------------------------------------
module core_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int INDEX_AW   = 8,
    parameter int TAG_W      = 20,
    parameter int OFFSET_AW  = 4,
    parameter int RAM_NUM    = 4,
    parameter int LINE_WORDS = 2 ** (OFFSET_AW - 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cache_req_i,
    input  logic                 cache_op_i,
    input  logic [INDEX_AW-1:0]  cache_index_i,
    input  logic [TAG_W-1:0]     cache_tag_i,
    input  logic [OFFSET_AW-1:0] cache_offset_i,
    input  logic [RAM_NUM-1:0]   cache_wr_en_i,
    input  logic [DATA_W-1:0]    cache_wr_data_i,
    output logic [DATA_W-1:0]    cache_rd_data_o,
    output logic                 cache_addr_ack_o,
    output logic                 cache_data_ack_o,
    output logic                 mem_rd_req_o,
    output logic [ADDR_W-1:0]    mem_rd_addr_o,
    input  logic                 mem_rd_ack_i,
    input  logic                 mem_rd_valid_i,
    input  logic [DATA_W-1:0]    mem_rd_data_i,
    output logic                 mem_wr_req_o,
    output logic [ADDR_W-1:0]    mem_wr_addr_o,
    output logic [DATA_W-1:0]    mem_wr_data_o,
    output logic [RAM_NUM-1:0]   mem_wr_strb_o,
    input  logic                 mem_wr_ack_i
);

    localparam int WORD_AW = $clog2(LINE_WORDS);
    localparam int LINES   = 1 << INDEX_AW;
    localparam int BYTE_W  = DATA_W / RAM_NUM;

    localparam logic [WORD_AW-1:0] LAST_BEAT = WORD_AW'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MISS_REQ = 3'd2;
    localparam logic [2:0] S_REFILL   = 3'd3;
    localparam logic [2:0] S_WR_MEM   = 3'd4;

    logic [2:0]          r_state;
    logic                r_op;
    logic [INDEX_AW-1:0] r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic [WORD_AW-1:0]  r_off_w;
    logic [RAM_NUM-1:0]  r_wr_en;
    logic [DATA_W-1:0]   r_wr_data;
    logic [WORD_AW-1:0]  r_cnt;
    logic [LINES-1:0]    r_valid;

    logic [TAG_W-1:0]    r_tag_arr  [LINES];
    logic [DATA_W-1:0]   r_data_arr [LINES][LINE_WORDS];

    logic w_hit;
    logic w_lookup;
    logic w_rd_hit;
    logic w_wr_hit;
    logic w_beat;
    logic w_last_beat;
    logic w_unused_offset;

    // Byte-within-word offset bits carry no meaning for a word-wide cache.
    assign w_unused_offset = ^cache_offset_i[1:0];

    assign w_hit       = r_valid[r_idx] && (r_tag_arr[r_idx] == r_tag);
    assign w_lookup    = (r_state == S_LOOKUP);
    assign w_rd_hit    = w_lookup && !r_op && w_hit;
    assign w_wr_hit    = w_lookup && r_op && w_hit;
    assign w_beat      = (r_state == S_REFILL) && mem_rd_valid_i;
    assign w_last_beat = w_beat && (r_cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= 1'b0;
            r_idx     <= '0;
            r_tag     <= '0;
            r_off_w   <= '0;
            r_wr_en   <= '0;
            r_wr_data <= '0;
            r_cnt     <= '0;
            r_valid   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cache_req_i) begin
                        r_op      <= cache_op_i;
                        r_idx     <= cache_index_i;
                        r_tag     <= cache_tag_i;
                        r_off_w   <= cache_offset_i[OFFSET_AW-1:2];
                        r_wr_en   <= cache_wr_en_i;
                        r_wr_data <= cache_wr_data_i;
                        r_state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (r_op) begin
                        r_state <= S_WR_MEM;
                    end else if (w_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        // The line is about to be overwritten beat by beat, so it
                        // must stop hitting before the first beat lands.
                        r_valid[r_idx] <= 1'b0;
                        r_state        <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (mem_rd_ack_i) begin
                        r_cnt   <= '0;
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_valid[r_idx] <= 1'b1;
                            // Re-run the lookup so the read is answered by the hit path.
                            r_state        <= S_LOOKUP;
                        end
                    end
                end
                S_WR_MEM: begin
                    if (mem_wr_ack_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data_arr[r_idx][r_cnt] <= mem_rd_data_i;
        end
        if (w_last_beat) begin
            r_tag_arr[r_idx] <= r_tag;
        end
        if (w_wr_hit) begin
            for (int b = 0; b < RAM_NUM; b++) begin
                if (r_wr_en[b]) begin
                    r_data_arr[r_idx][r_off_w][b*BYTE_W +: BYTE_W] <= r_wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign cache_addr_ack_o = (r_state == S_IDLE) && cache_req_i;
    assign cache_data_ack_o = w_rd_hit || ((r_state == S_WR_MEM) && mem_wr_ack_i);
    assign cache_rd_data_o  = w_rd_hit ? r_data_arr[r_idx][r_off_w] : '0;

    assign mem_rd_req_o  = (r_state == S_MISS_REQ);
    assign mem_rd_addr_o = mem_rd_req_o ? {r_tag, r_idx, {OFFSET_AW{1'b0}}} : '0;

    assign mem_wr_req_o  = (r_state == S_WR_MEM);
    assign mem_wr_addr_o = mem_wr_req_o ? {r_tag, r_idx, r_off_w, 2'b00} : '0;
    assign mem_wr_data_o = mem_wr_req_o ? r_wr_data : '0;
    assign mem_wr_strb_o = mem_wr_req_o ? r_wr_en : '0;

endmodule
